// File: rtl/bcd_convertidor_secuencial.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one input bit per cycle)
// with overflow flag and active-low seven-segment outputs with leading-zero blanking.
module bcd_convertidor_secuencial #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_sr, bin_sr_nxt;
  logic [BCD_W-1:0]   bcd_sr, bcd_sr_nxt, bcd_adj, bcd_out_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf_sticky, ovf_sticky_nxt;
  logic               overflow_nxt, done_nxt;
  logic               nz_above;
  logic [3:0]         seg_digit;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Segment order {g,f,e,d,c,b,a}, active low
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = add3(bcd_sr[4*i +: 4]);
  end

  always_comb begin
    state_nxt      = state;
    bin_sr_nxt     = bin_sr;
    bcd_sr_nxt     = bcd_sr;
    cnt_nxt        = cnt;
    ovf_sticky_nxt = ovf_sticky;
    bcd_out_nxt    = bcd_out;
    overflow_nxt   = overflow;
    done_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt      = CONV;
          bin_sr_nxt     = bin_in;
          bcd_sr_nxt     = '0;
          cnt_nxt        = '0;
          ovf_sticky_nxt = 1'b0;
        end
      end
      CONV: begin
        // A 1 shifted out of the top digit means the value no longer fits
        bcd_sr_nxt     = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
        bin_sr_nxt     = {bin_sr[BIN_W-2:0], 1'b0};
        ovf_sticky_nxt = ovf_sticky | bcd_adj[BCD_W-1];
        cnt_nxt        = cnt + CNT_W'(1);
        if (cnt_nxt == CNT_W'(BIN_W)) begin
          bcd_out_nxt  = bcd_sr_nxt;
          overflow_nxt = ovf_sticky_nxt;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bin_sr     <= '0;
      bcd_sr     <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bin_sr     <= bin_sr_nxt;
      bcd_sr     <= bcd_sr_nxt;
      cnt        <= cnt_nxt;
      ovf_sticky <= ovf_sticky_nxt;
      bcd_out    <= bcd_out_nxt;
      overflow   <= overflow_nxt;
      done       <= done_nxt;
    end
  end

  assign busy = (state == CONV);

  // Walk from the most significant digit down; digit 0 is always shown
  always_comb begin
    nz_above  = 1'b0;
    seg_digit = '0;
    seg_out   = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seg_digit = bcd_out[4*i +: 4];
      nz_above  = nz_above | (seg_digit != 4'd0);
      if (blank_lz && !nz_above && (i != 0))
        seg_out[7*i +: 7] = 7'b1111111;
      else
        seg_out[7*i +: 7] = seg7(seg_digit);
    end
  end

endmodule

// File: tb/tb_bcd_convertidor_secuencial.sv
// Scoreboard bench: two converter instances (10b/4 digits and 8b/2 digits)
// checked against an arithmetic decimal model.
module tb_bcd_convertidor_secuencial;

  localparam int W0 = 10, D0 = 4;
  localparam int W1 = 8,  D1 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start0, blank0, busy0, done0, ovf0;
  logic [W0-1:0]     bin0;
  logic [4*D0-1:0]   bcd0;
  logic [7*D0-1:0]   seg0;
  logic              start1, blank1, busy1, done1, ovf1;
  logic [W1-1:0]     bin1;
  logic [4*D1-1:0]   bcd1;
  logic [7*D1-1:0]   seg1;

  bcd_convertidor_secuencial #(.BIN_W(W0), .DIGITS(D0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .bin_in(bin0), .blank_lz(blank0),
    .busy(busy0), .done(done0), .bcd_out(bcd0), .overflow(ovf0), .seg_out(seg0));

  bcd_convertidor_secuencial #(.BIN_W(W1), .DIGITS(D1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bin_in(bin1), .blank_lz(blank1),
    .busy(busy1), .done(done1), .bcd_out(bcd1), .overflow(ovf1), .seg_out(seg1));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nfail = 0;

  typedef struct { int unsigned v; int acc; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [63:0] bcd_ref(input int unsigned v, input int d);
    logic [63:0] r = '0;
    longint unsigned m = v % pow10(d);
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((m / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [63:0] seg_model(input int unsigned v, input int d, input bit bl);
    logic [63:0] r = '0;
    longint unsigned m = v % pow10(d);
    for (int i = 0; i < d; i++) begin
      if (bl && i > 0 && m < pow10(i)) r[7*i +: 7] = 7'b1111111;
      else r[7*i +: 7] = seg_ref(int'((m / pow10(i)) % 10));
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) chk("u0_unexpected_done", done0, 0);
      else begin
        e = q0.pop_front();
        chk("u0_bcd", bcd0, bcd_ref(e.v, D0));
        chk("u0_ovf", ovf0, 64'(e.v >= pow10(D0)));
        chk("u0_seg", seg0, seg_model(e.v, D0, blank0));
        chk("u0_latency", cyc, e.acc + W0);
        chk("u0_busy_with_done", busy0, 0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("u1_unexpected_done", done1, 0);
      else begin
        e = q1.pop_front();
        chk("u1_bcd", bcd1, bcd_ref(e.v, D1));
        chk("u1_ovf", ovf1, 64'(e.v >= pow10(D1)));
        chk("u1_seg", seg1, seg_model(e.v, D1, blank1));
        chk("u1_latency", cyc, e.acc + W1);
        chk("u1_busy_with_done", busy1, 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle0();
    int n = 0;
    while (busy0 === 1'b1 && n < 100) begin step(); n++; end
    if (n >= 100) chk("u0_idle_timeout", busy0, 0);
  endtask

  task automatic wait_idle1();
    int n = 0;
    while (busy1 === 1'b1 && n < 100) begin step(); n++; end
    if (n >= 100) chk("u1_idle_timeout", busy1, 0);
  endtask

  task automatic issue0(input int unsigned v, input bit bl);
    wait_idle0();
    bin0 = v[W0-1:0];
    blank0 = bl;
    start0 = 1'b1;
    q0.push_back(exp_t'{v, cyc + 1});
    step();
    start0 = 1'b0;
  endtask

  task automatic issue1(input int unsigned v, input bit bl);
    wait_idle1();
    bin1 = v[W1-1:0];
    blank1 = bl;
    start1 = 1'b1;
    q1.push_back(exp_t'{v, cyc + 1});
    step();
    start1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start0 = 1'b0; bin0 = '0; blank0 = 1'b0;
    start1 = 1'b0; bin1 = '0; blank1 = 1'b1;
    step();
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_bcd0", bcd0, 0);
    chk("rst_ovf0", ovf0, 0);
    chk("rst_seg0", seg0, seg_model(0, D0, 0));
    chk("rst_seg1_blank", seg1, seg_model(0, D1, 1));
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    step();

    issue0(1023, 0);
    issue0(0, 1);
    issue0(0, 0);
    issue0(7, 1);
    issue0(7, 0);

    // Extra starts and input changes during a conversion must be ignored
    issue0(500, 0);
    repeat (2) step();
    start0 = 1'b1; bin0 = W0'($urandom_range(1023, 0));
    step();
    start0 = 1'b0;
    repeat (3) step();
    start0 = 1'b1; bin0 = W0'($urandom_range(1023, 0));
    step();
    start0 = 1'b0;

    // Reset in the middle of a conversion aborts it
    issue0(42, 0);
    issue0(999, 0);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midrst_busy0", busy0, 0);
    chk("midrst_done0", done0, 0);
    chk("midrst_bcd0", bcd0, 0);
    chk("midrst_ovf0", ovf0, 0);
    chk("midrst_seg0", seg0, seg_model(0, D0, blank0));
    q0.delete();
    step();
    rst = 1'b0;
    step();
    issue0(12, 0);

    // start held high: each idle cycle accepts the next value
    wait_idle0();
    blank0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_idle0();
      bin0 = W0'(k);
      start0 = 1'b1;
      q0.push_back(exp_t'{k, cyc + 1});
      step();
    end
    start0 = 1'b0;

    for (int k = 0; k < 25; k++)
      issue0($urandom_range(1023, 0), bit'($urandom_range(1, 0)));

    issue1(255, 0);
    issue1(99, 1);
    issue1(100, 1);
    issue1(100, 0);
    for (int k = 0; k < 15; k++)
      issue1($urandom_range(255, 0), bit'($urandom_range(1, 0)));

    wait_idle0();
    wait_idle1();
    repeat (3) step();
    chk("u0_outstanding", q0.size(), 0);
    chk("u1_outstanding", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/bcd_convertidor_secuencial.md
# bcd_convertidor_secuencial

Parametrised sequential binary-to-BCD converter with seven-segment outputs. It replaces fixed-width combinational divide/modulo digit extraction with an iterative shift-and-add-3 (double-dabble) engine. The engine takes one cycle per input bit and uses a start/busy/done handshake. It sits between any binary producer (counter, ADC, switches) and the multi-digit seven-segment display, and adds overflow detection and leading-zero blanking.

## Interface
- BIN_W, 10, binary input width; legal range 4..32
- DIGITS, 4, number of BCD digits and displays; legal range 1..8
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high: one clock, asynchronous active-high reset
- start  input  1  request conversion of bin_in; sampled only in IDLE
- bin_in  input  BIN_W  unsigned binary value; captured on the accepting edge only
- blank_lz  input  1  1 = blank leading-zero digits on seg_out (digit 0 never blanked)
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse; bcd_out/overflow valid and updated in that cycle
- bcd_out  output  4*DIGITS  registered result; digit i at [4i+3:4i], digit 0 = units
- overflow  output  1  registered; 1 = bin_in >= 10^DIGITS, bcd_out holds value mod 10^DIGITS
- seg_out  output  7*DIGITS  active-low segments; digit i at [7i+6:7i], bit 7i+0 = a … 7i+6 = g

## Operation
- States: IDLE, CONV. Working regs: bin shift reg (BIN_W), BCD shift reg (4*DIGITS), iteration counter ($clog2(BIN_W+1) bits), sticky overflow bit.
- IDLE: start=1 at an edge -> load bin_in, clear BCD reg, counter and sticky bit, go CONV. start=0 -> stay.
- CONV, each edge: every BCD digit >= 5 gets +3 (4-bit, no carry between digits). Then {BCD, bin} shifts left by 1. If the bit leaving the top digit is 1, set the sticky overflow bit. Counter increments.
- When the counter reaches BIN_W (the BIN_W-th CONV edge):
  - bcd_out <= final BCD value, overflow <= final sticky value, done <= 1, state -> IDLE.
- start while in CONV is ignored and not queued; bin_in changes during CONV have no effect.
- bcd_out and overflow hold their value between completions; they are not cleared at start.
- Overflow truncation: digits above DIGITS are discarded, giving bcd_out = bin_in mod 10^DIGITS, with overflow = 1.
- seg_out: combinational from bcd_out and blank_lz.
  - Standard hex-free decimal map; for example '0' = 7'b1000000, '1' = 7'b1111001, '8' = 7'b0000000.
  - Codes 10..15 cannot occur; drive blank (7'b1111111).
- Leading-zero blanking, when blank_lz=1: a digit i>0 is blanked when it and all digits above it are 0.
- overflow does not alter seg_out.

## Timing
- Reset values (async on rst rising, held while high):
  - state IDLE, busy 0, done 0, overflow 0, bcd_out 0, internal regs 0.
  - seg_out shows "0000", or only digit 0 showing '0' when blank_lz=1.
- Accept edge k (IDLE, start=1): busy high from edge k through edge k+BIN_W, i.e. BIN_W cycles.
- Edge k+BIN_W: busy falls, done rises for exactly one cycle, and bcd_out/overflow are updated in that same cycle.
- Latency start-edge to done = BIN_W cycles.
- done and busy are never high together.
- Back-to-back: start high during the done cycle is accepted at edge k+BIN_W+1, giving throughput of one result per BIN_W+1 cycles.
- start held high continuously: a new conversion every BIN_W+1 cycles.
- rst mid-conversion: the conversion is aborted and all outputs go to reset values immediately. No done pulse. The first start after rst is deasserted behaves as from power-up.
- BIN_W=DIGITS*4 exact-fit and BIN_W smaller than the digit capacity are both legal; overflow can only be 1 when 2^BIN_W > 10^DIGITS.

## Test plan
- Defaults, bin_in=1023, start one cycle: busy for 10 cycles; done at edge 10; bcd_out=16'h1023, overflow=0, seg_out digits 3..0 = '1','0','2','3'.
- bin_in=0 and bin_in=7 with blank_lz=1 then 0:
  - blank_lz=1: digits 3..1 = 7'b1111111, digit 0 shows '0' or '7'.
  - blank_lz=0: all digits shown.
- BIN_W=8, DIGITS=2:
  - bin_in=255 -> bcd_out=8'h55, overflow=1.
  - bin_in=99 -> 8'h99, overflow=0.
  - bin_in=100 -> 8'h00, overflow=1.
- start pulsed again and bin_in changed at cycles 3 and 7 of a conversion of 500: ignored; a single done; bcd_out=16'h0500.
- rst asserted at cycle 5 of a conversion of 999 (prior result 16'h0042): all outputs reset asynchronously, no done. A new start of 12 completes normally with 16'h0012.
- start held high with bin_in stepping 1,2,3: done every 11 cycles; results 16'h0001, 16'h0002, 16'h0003 in order.
